// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: NUM_REQ bursting producers share one FIFO write port.
// Define ARB_STATS_EN to build the per-requester saturating beat counters.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      fifo_wr,
  output logic [DATA_W-1:0]         fifo_din,
  input  logic                      fifo_full,
  output logic [2:0]                grant_id,
  output logic                      busy,
  output logic [16*NUM_REQ-1:0]     stat_beats
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t     r_state, w_state_nx;
  logic [2:0] r_gid, w_gid_nx;
  logic [2:0] r_rr_ptr, w_rr_nx;
  logic [3:0] r_beat_cnt, w_cnt_nx;

  logic          w_found;
  logic [2:0]    w_pick;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_g;
  logic          w_active;
  logic          w_beat;
  logic          w_release;

  assign w_g      = r_gid[IW-1:0];
  assign w_active = (r_state == S_GRANT) && !rst;
  assign busy     = (r_state == S_GRANT);
  assign grant_id = r_gid;

  // Descending scan so the nearest set bit after rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = IW'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (req_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = 3'(w_idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    w_beat    = 1'b0;
    fifo_din  = '0;
    if (w_active) begin
      req_ready[w_g] = !fifo_full;
      w_beat         = req_valid[w_g] && !fifo_full;
    end
    if (w_beat) begin
      fifo_din = req_data[int'(w_g)*DATA_W +: DATA_W];
    end
    fifo_wr = w_beat;
  end

  always_comb begin
    w_state_nx = r_state;
    w_gid_nx   = r_gid;
    w_rr_nx    = r_rr_ptr;
    w_cnt_nx   = r_beat_cnt;
    w_release  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nx = S_GRANT;
          w_gid_nx   = w_pick;
          w_cnt_nx   = '0;
        end
      end
      S_GRANT: begin
        if (w_beat) begin
          w_cnt_nx = r_beat_cnt + 4'd1;
        end
        w_release = !req_valid[w_g] ||
                    (w_beat && (req_last[w_g] ||
                                w_cnt_nx == 4'(MAX_BURST)));
        if (w_release) begin
          w_state_nx = S_IDLE;
          w_rr_nx    = r_gid;
          w_cnt_nx   = '0;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gid      <= '0;
      r_rr_ptr   <= 3'(NUM_REQ - 1);
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_gid      <= w_gid_nx;
      r_rr_ptr   <= w_rr_nx;
      r_beat_cnt <= w_cnt_nx;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] r_stat [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_stat[i] <= '0;
      end
    end else if (w_beat && r_stat[w_g] != 16'hFFFF) begin
      r_stat[w_g] <= r_stat[w_g] + 16'd1;
    end
  end

  always_comb begin
    stat_beats = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_beats[i*16 +: 16] = r_stat[i];
    end
  end
`else
  assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter.
// Producers push expected beats per requester; a negedge monitor checks.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_wr;
  logic [W-1:0]   fifo_din;
  logic           fifo_full;
  logic [2:0]     grant_id;
  logic           busy;
  logic [16*N-1:0] stat_beats;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .fifo_wr(fifo_wr), .fifo_din(fifo_din), .fifo_full(fifo_full),
    .grant_id(grant_id), .busy(busy), .stat_beats(stat_beats)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_beats = 0;

  logic [W-1:0] exp_q [N][$];
  logic [W-1:0] cur_data [N];
  logic         cur_last [N];
  bit           has_item [N];
  int           seqn [N];
  int           stat_m [N];
  logic [N-1:0] acc;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Round-robin rule: first valid requester after the last one served.
  function automatic int winner(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return 0;
  endfunction

  bit           started = 0;
  bit           p_rst = 0;
  bit           p_busy = 0;
  bit           p_rel = 0;
  int           p_gid = 0;
  logic [N-1:0] p_vec = '0;
  int           last_srv = N - 1;
  int           cnt = 0;

  always @(negedge clk) begin
    int g;
    logic exp_wr;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] d;
    if (started) begin
      if (p_rst) begin
        chk("rst_busy", busy, 0);
        chk("rst_gid", grant_id, 0);
      end else if (p_busy) begin
        if (p_rel) chk("release", busy, 0);
        else begin
          chk("hold_busy", busy, 1);
          chk("hold_gid", grant_id, p_gid);
        end
      end else if (p_vec != 0) begin
        chk("arb_busy", busy, 1);
        chk("arb_gid", grant_id, winner(p_vec, last_srv));
      end else begin
        chk("idle_busy", busy, 0);
      end
    end
    if (rst) begin
      chk("rst_wr", fifo_wr, 0);
      chk("rst_ready", req_ready, 0);
      started = 1; p_rst = 1; p_busy = 0; p_rel = 0; p_vec = '0;
      last_srv = N - 1; cnt = 0; acc = '0;
      for (int i = 0; i < N; i++) stat_m[i] = 0;
    end else if (started) begin
      p_rst = 0;
      acc = req_ready & req_valid;
      if (busy) begin
        g = int'(grant_id) % N;
        exp_rdy = fifo_full ? '0 : N'(1) << g;
        exp_wr = req_valid[g] && !fifo_full;
        chk("ready", req_ready, exp_rdy);
        chk("wr", fifo_wr, exp_wr);
        if (exp_wr) begin
          cnt++; n_beats++; stat_m[g]++;
          if (exp_q[g].size() == 0) chk("queue_empty", 1, 0);
          else begin
            d = exp_q[g].pop_front();
            chk("din", fifo_din, d);
          end
        end else chk("din_idle", fifo_din, 0);
        p_rel = !req_valid[g] || (exp_wr && (req_last[g] || cnt == MB));
        if (p_rel) begin
          last_srv = g; cnt = 0;
        end
        p_gid = g; p_busy = 1;
      end else begin
        chk("idle_wr", fifo_wr, 0);
        chk("idle_ready", req_ready, 0);
        p_vec = req_valid; p_busy = 0; cnt = 0;
      end
    end
  end

  task automatic step(input logic [N-1:0] en, input int vpct,
                      input int lpct, input int fpct);
    for (int i = 0; i < N; i++) begin
      if (acc[i]) has_item[i] = 0;
      if (!has_item[i] && en[i]) begin
        cur_data[i] = W'((i << 5) | (seqn[i] & 31));
        cur_last[i] = ($urandom_range(0, 99) < lpct);
        seqn[i]++;
        exp_q[i].push_back(cur_data[i]);
        has_item[i] = 1;
      end
      req_valid[i] = has_item[i] && en[i] &&
                     ($urandom_range(0, 99) < vpct);
      req_last[i] = cur_last[i];
      req_data[i*W +: W] = cur_data[i];
    end
    fifo_full = ($urandom_range(0, 99) < fpct);
  endtask

  task automatic run(input logic [N-1:0] en, input int vpct,
                     input int lpct, input int fpct, input int ncyc);
    repeat (ncyc) begin
      @(posedge clk); #1;
      step(en, vpct, lpct, fpct);
    end
  endtask

  task automatic reset_mid_burst();
    bit hit;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(posedge clk); #1;
      step(N'(1), 100, 0, 0);
      hit = busy;
    end
    if (!hit) begin
      n_cmp++; n_err++;
      $display("FAIL wait_busy: got no grant expected grant within 40 cycles");
    end
    @(posedge clk); #1;
    step(N'(1), 100, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    step(N'(1), 100, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      has_item[i] = 0; seqn[i] = 0; cur_data[i] = '0; cur_last[i] = 0;
      stat_m[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    run(4'hF, 100, 100, 0, 40);
    run(4'b0100, 100, 0, 0, 30);
    run(4'b0010, 100, 30, 0, 6);
    run(4'b0010, 100, 30, 100, 3);
    run(4'b0010, 100, 30, 0, 10);
    run(4'b1000, 60, 20, 0, 30);
    reset_mid_burst();
    run(4'hF, 80, 30, 25, 400);
    run(4'hF, 100, 50, 0, 200);
    run(4'h0, 100, 0, 0, 4);
    @(negedge clk);
    chk("progress", n_beats > 100, 1);
    for (int i = 0; i < N; i++) begin
`ifdef ARB_STATS_EN
      chk("stat", stat_beats[i*16 +: 16], 16'(stat_m[i]));
`else
      chk("stat_zero", stat_beats[i*16 +: 16], 0);
`endif
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
